// File: rtl/pico_io_responder.sv
// KCPSM6 I/O responder: TX holding register, RX FIFO, CTRL/STATUS/GPIO and a level interrupt.
// Define PICO_IO_KWRITE_EN to let OUTPUTK (k_write_strobe) write the register window.
module pico_io_responder #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         FIFO_AW   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       k_write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         ctrl;
  logic [7:0]         gpio_q;
  logic               overflow;
  logic               tx_drop;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               rx_empty;
  logic               rx_full;
  logic               in_win;
  logic [1:0]         offset;
  logic               wr_en;
  logic               push;
  logic               pop;
  logic               tx_wr;
  logic               ctrl_wr;
  logic               flag_wr;
  logic               gpio_wr;
  logic [3:0]         cnt_sat;
  logic [7:0]         status;
  logic [7:0]         rd_data;

  assign rx_empty = (count == '0);
  assign rx_full  = (count == DEPTH_C);
  assign rx_ready = ~rx_full;

  // BASE_ADDR[1:0] is zero, so the low two port_id bits are the register offset.
  assign in_win = (port_id[7:2] == BASE_ADDR[7:2]);
  assign offset = port_id[1:0];

`ifdef PICO_IO_KWRITE_EN
  // OUTPUTK only carries a 4-bit port, so the upper nibble is don't-care.
  logic k_hit;
  assign k_hit = k_write_strobe & (port_id[3:2] == BASE_ADDR[3:2]);
  assign wr_en = (write_strobe & in_win) | k_hit;
`else
  logic unused_k_write_strobe;
  assign unused_k_write_strobe = k_write_strobe;
  assign wr_en = write_strobe & in_win;
`endif

  assign tx_wr   = wr_en & (offset == 2'd0);
  assign ctrl_wr = wr_en & (offset == 2'd1);
  assign flag_wr = wr_en & (offset == 2'd2);
  assign gpio_wr = wr_en & (offset == 2'd3);

  assign push = rx_valid & ~rx_full;
  assign pop  = read_strobe & in_win & (offset == 2'd0) & ~rx_empty;

  always_comb begin
    cnt_sat = 4'hF;
    if (int'(count) < 15) cnt_sat = 4'(count);
  end

  assign status = {cnt_sat, tx_drop, overflow, rx_full, rx_empty};

  always_comb begin
    rd_data = 8'h00;
    if (in_win) begin
      case (offset)
        2'd0:    rd_data = rx_empty ? 8'h00 : mem[rd_ptr];
        2'd1:    rd_data = ctrl;
        2'd2:    rd_data = status;
        default: rd_data = gpio_q;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_port   <= 8'h00;
      interrupt <= 1'b0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      gpio_out  <= 8'h00;
      gpio_q    <= 8'h00;
      ctrl      <= 8'h00;
      overflow  <= 1'b0;
      tx_drop   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      in_port   <= rd_data;
      gpio_q    <= gpio_in;
      interrupt <= (ctrl[0] & ~rx_empty) | (ctrl[1] & (overflow | tx_drop));

      if (ctrl_wr) ctrl <= out_port;
      if (gpio_wr) gpio_out <= out_port;

      // A write into a busy TX register is dropped even if the handshake completes now.
      if (tx_wr && !tx_valid) begin
        tx_data  <= out_port;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      if (tx_wr && tx_valid)             tx_drop <= 1'b1;
      else if (flag_wr && out_port[3])   tx_drop <= 1'b0;

      if (rx_valid && rx_full)           overflow <= 1'b1;
      else if (flag_wr && out_port[2])   overflow <= 1'b0;

      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_io_responder.sv
// Self-checking bench for pico_io_responder: a reference byte queue models the RX FIFO and
// a scoreboard queue holds the in_port value expected for each issued INPUT.
module tb_pico_io_responder;

  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] port_id = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       write_strobe = 1'b0;
  logic       k_write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;
  logic       interrupt;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] rx_model [$];
  logic [7:0] sb [$];

  pico_io_responder #(.BASE_ADDR(BASE), .FIFO_AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
    .in_port(in_port), .interrupt(interrupt), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
    port_id = p; read_strobe = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    read_strobe = 1'b0;
    chk(tag, in_port, sb.pop_front());
  endtask

  task automatic rd_fifo(input string tag);
    logic [7:0] e;
    e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
    rd(tag, BASE, e);
  endtask

  task automatic push_b(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    if (rx_model.size() < 16) rx_model.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_model.delete();
  endtask

  initial begin
    logic [7:0] e;
    do_reset();

    chk("rst_in_port", in_port, 8'h00);
    chk("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("rst_irq", {7'd0, interrupt}, 8'h00);
    chk("rst_gpio_out", gpio_out, 8'h00);
    rd("rst_status", BASE + 8'd2, 8'h01);

    push_b(8'hA5);
    push_b(8'h3C);
    rd("two_status", BASE + 8'd2, 8'h20);
    rd_fifo("pop_a5");
    rd_fifo("pop_3c");
    rd("empty_status", BASE + 8'd2, 8'h01);
    rd_fifo("pop_empty");
    rd("empty_pop_noflag", BASE + 8'd2, 8'h01);

    // Fill, overflow, set-wins-over-clear, clear, pop while full, drain.
    for (int i = 0; i < 17; i++) begin
      push_b(8'h10 + 8'(i));
      if (i == 15) chk("full_rx_ready", {7'd0, rx_ready}, 8'h00);
    end
    rd("ovf_status", BASE + 8'd2, 8'hF6);
    rx_data = 8'hEE; rx_valid = 1'b1;
    wr(BASE + 8'd2, 8'h04);
    rx_valid = 1'b0;
    rd("set_wins", BASE + 8'd2, 8'hF6);
    wr(BASE + 8'd2, 8'h04);
    rd("ovf_clr_status", BASE + 8'd2, 8'hF2);
    rd_fifo("pop_full");
    chk("ready_after_pop", {7'd0, rx_ready}, 8'h01);
    for (int i = 0; i < 15; i++) rd_fifo("drain");
    rd("drained_status", BASE + 8'd2, 8'h01);

    // Simultaneous push and pop keeps count and order.
    push_b(8'h11);
    push_b(8'h22);
    rx_data = 8'h33; rx_valid = 1'b1;
    rx_model.push_back(8'h33);
    rd_fifo("simul_pop");
    rx_valid = 1'b0;
    rd("simul_status", BASE + 8'd2, 8'h20);
    rd_fifo("simul_22");
    rd_fifo("simul_33");

    // TX handshake and drop.
    wr(BASE, 8'h55);
    chk("tx_valid_set", {7'd0, tx_valid}, 8'h01);
    chk("tx_data_55", tx_data, 8'h55);
    wr(BASE, 8'h66);
    chk("tx_data_hold", tx_data, 8'h55);
    rd("drop_status", BASE + 8'd2, 8'h09);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("tx_valid_clr", {7'd0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    wr(BASE + 8'd2, 8'h08);
    rd("drop_clr_status", BASE + 8'd2, 8'h01);
    wr(BASE, 8'h77);
    tx_ready = 1'b1;
    wr(BASE, 8'h88);
    tx_ready = 1'b0;
    chk("tx_busy_ready_valid", {7'd0, tx_valid}, 8'h00);
    chk("tx_busy_ready_data", tx_data, 8'h77);
    rd("tx_busy_ready_drop", BASE + 8'd2, 8'h09);

    // CTRL readback and interrupts.
    wr(BASE + 8'd1, 8'hA8);
    rd("ctrl_rb", BASE + 8'd1, 8'hA8);
    wr(BASE + 8'd1, 8'h02);
    @(negedge clk);
    chk("irq_err_on", {7'd0, interrupt}, 8'h01);
    wr(BASE + 8'd2, 8'h08);
    @(negedge clk);
    chk("irq_err_off", {7'd0, interrupt}, 8'h00);
    wr(BASE + 8'd1, 8'h01);
    push_b(8'h5E);
    chk("irq_lag", {7'd0, interrupt}, 8'h00);
    @(negedge clk);
    chk("irq_rx_on", {7'd0, interrupt}, 8'h01);
    rd_fifo("irq_pop");
    chk("irq_hold", {7'd0, interrupt}, 8'h01);
    @(negedge clk);
    chk("irq_rx_off", {7'd0, interrupt}, 8'h00);
    wr(BASE + 8'd1, 8'h00);

    // GPIO and window decode.
    wr(BASE + 8'd3, 8'hC3);
    chk("gpio_out_c3", gpio_out, 8'hC3);
    gpio_in = 8'h5A;
    @(negedge clk);
    rd("gpio_in_5a", BASE + 8'd3, 8'h5A);
    wr(8'h03, 8'hFF);
    chk("outside_wr", gpio_out, 8'hC3);
    rd("outside_rd_gpio", 8'h03, 8'h00);
    push_b(8'h99);
    rd("outside_rd_nopop", 8'h00, 8'h00);
    rd_fifo("after_outside");

    // Reset mid-transfer discards FIFO and TX state.
    push_b(8'h01);
    push_b(8'h02);
    wr(BASE, 8'hAB);
    do_reset();
    chk("rst2_tx_valid", {7'd0, tx_valid}, 8'h00);
    chk("rst2_rx_ready", {7'd0, rx_ready}, 8'h01);
    chk("rst2_gpio_out", gpio_out, 8'h00);
    rd("rst2_status", BASE + 8'd2, 8'h01);
    rd_fifo("rst2_empty");

    port_id = 8'hF3; out_port = 8'h9A; k_write_strobe = 1'b1;
    @(negedge clk);
    k_write_strobe = 1'b0;
`ifdef PICO_IO_KWRITE_EN
    e = 8'h9A;
`else
    e = 8'h00;
`endif
    chk("kwrite_gpio", gpio_out, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
